// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island definitions: packet type codes, IEC block length and
// the arbitration outcome encoding used by the scheduler.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_SPD          = 8'h83;
    localparam logic [7:0] PKT_AUDIO_INFO   = 8'h84;

    localparam int IEC_FRAMES_PER_BLOCK = 192;

    typedef enum logic [1:0] {
        GRANT_NULL,
        GRANT_ACR,
        GRANT_AUDIO,
        GRANT_INFO
    } grant_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Circular sample FIFO: valid/ready push, and a pop of several entries at once
// with the oldest entries always visible on head_data.
module audio_sample_fifo #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int MAX_POP = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int POP_W  = $clog2(MAX_POP + 1)
) (
    input  logic                            clk_pixel,
    input  logic                            reset_n,
    input  logic                            push_valid,
    output logic                            push_ready,
    input  logic [WIDTH-1:0]                push_data,
    input  logic [POP_W-1:0]                pop_count,
    output logic [MAX_POP-1:0][WIDTH-1:0]   head_data,
    output logic [CNT_W-1:0]                count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;

    assign push_ready = (count != CNT_W'(DEPTH));
    assign push       = push_valid && push_ready;

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_count);
            count  <= count + CNT_W'(push) - CNT_W'(pop_count);
        end
    end

    always_comb begin
        for (int k = 0; k < MAX_POP; k++) begin
            head_data[k] = mem[rd_ptr + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/packet_scheduler.sv
// Picks the HDMI data-island packet for each packet_enable slot: ACR with
// anti-starvation, packed audio samples, repeating InfoFrames, else null.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH        = 16,
    parameter int MAX_SAMPLES_PER_PACKET = 2,
    parameter int AUDIO_FIFO_DEPTH       = 8,
    parameter int NUM_INFOFRAMES         = 3,
    parameter logic [8*NUM_INFOFRAMES-1:0] INFOFRAME_TYPES = {PKT_SPD, PKT_AVI, PKT_AUDIO_INFO},
    parameter int REPEAT_FIELDS          = 2
) (
    input  logic                              clk_pixel,
    input  logic                              reset_n,
    input  logic                              packet_enable,
    input  logic                              video_field_end,
    input  logic                              audio_sample_valid,
    output logic                              audio_sample_ready,
    input  logic [1:0][AUDIO_BIT_WIDTH-1:0]   audio_sample_word,
    input  logic                              acr_request,
    input  logic [NUM_INFOFRAMES-1:0]         infoframe_update,
    output logic [7:0]                        packet_type,
    output logic [3:0][1:0][23:0]             audio_sample_word_packet,
    output logic [3:0]                        audio_sample_word_present,
    output logic [7:0]                        frame_counter,
    output logic [NUM_INFOFRAMES-1:0]         infoframe_pending
);

    localparam int SAMPLE_W = 2 * AUDIO_BIT_WIDTH;
    localparam int CNT_W    = $clog2(AUDIO_FIFO_DEPTH + 1);
    localparam int POP_W    = $clog2(MAX_SAMPLES_PER_PACKET + 1);
    localparam int PAD      = 24 - AUDIO_BIT_WIDTH;

    logic [CNT_W-1:0]                                fifo_count;
    logic [MAX_SAMPLES_PER_PACKET-1:0][SAMPLE_W-1:0] fifo_head;
    logic [POP_W-1:0]                                avail_n;
    logic [POP_W-1:0]                                pop_n;
    grant_e                                          grant;
    logic [7:0]                                      grant_type;
    logic [NUM_INFOFRAMES-1:0]                       info_onehot;
    logic [NUM_INFOFRAMES-1:0]                       info_clear;
    logic [7:0]                                      info_type;
    logic                                            info_hit;
    logic                                            acr_pending;
    logic                                            acr_skip;
    logic [3:0]                                      field_count;
    logic                                            field_wrap;
    logic [7:0]                                      next_frame;
    logic [8:0]                                      frame_sum;
    logic [7:0]                                      frame_adv;
    logic [3:0][1:0][23:0]                           packed_words;
    logic [3:0]                                      packed_present;

    audio_sample_fifo #(
        .WIDTH   (SAMPLE_W),
        .DEPTH   (AUDIO_FIFO_DEPTH),
        .MAX_POP (MAX_SAMPLES_PER_PACKET)
    ) u_fifo (
        .clk_pixel  (clk_pixel),
        .reset_n    (reset_n),
        .push_valid (audio_sample_valid),
        .push_ready (audio_sample_ready),
        .push_data  (audio_sample_word),
        .pop_count  (pop_n),
        .head_data  (fifo_head),
        .count      (fifo_count)
    );

    // Arbitration on pre-update state; descending scan leaves the lowest pending slot.
    always_comb begin
        info_hit    = 1'b0;
        info_type   = PKT_NULL;
        info_onehot = '0;
        for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
            if (infoframe_pending[i]) begin
                info_hit       = 1'b1;
                info_type      = INFOFRAME_TYPES[i*8 +: 8];
                info_onehot    = '0;
                info_onehot[i] = 1'b1;
            end
        end

        if (fifo_count >= CNT_W'(MAX_SAMPLES_PER_PACKET)) begin
            avail_n = POP_W'(MAX_SAMPLES_PER_PACKET);
        end else begin
            avail_n = POP_W'(fifo_count);
        end

        grant = GRANT_NULL;
        if (packet_enable) begin
            if (acr_pending && acr_skip)   grant = GRANT_ACR;
            else if (fifo_count != '0)     grant = GRANT_AUDIO;
            else if (acr_pending)          grant = GRANT_ACR;
            else if (info_hit)             grant = GRANT_INFO;
        end

        case (grant)
            GRANT_ACR:   grant_type = PKT_ACR;
            GRANT_AUDIO: grant_type = PKT_AUDIO_SAMPLE;
            GRANT_INFO:  grant_type = info_type;
            default:     grant_type = PKT_NULL;
        endcase

        pop_n      = (grant == GRANT_AUDIO) ? avail_n : '0;
        info_clear = (grant == GRANT_INFO) ? info_onehot : '0;
        field_wrap = video_field_end && (field_count == 4'(REPEAT_FIELDS - 1));
    end

    // Left-justify each sample into the 24-bit subpacket slot.
    always_comb begin
        packed_words = '0;
        for (int k = 0; k < MAX_SAMPLES_PER_PACKET; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (k < int'(avail_n)) begin
                    packed_words[k][c] = 24'(fifo_head[k][c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << PAD;
                end
            end
        end
        packed_present = 4'((5'd1 << avail_n) - 5'd1);
        frame_sum      = {1'b0, next_frame} + 9'(avail_n);
        frame_adv      = (frame_sum >= 9'(IEC_FRAMES_PER_BLOCK))
                         ? 8'(frame_sum - 9'(IEC_FRAMES_PER_BLOCK)) : frame_sum[7:0];
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            packet_type               <= PKT_NULL;
            audio_sample_word_packet  <= '0;
            audio_sample_word_present <= '0;
            frame_counter             <= '0;
            next_frame                <= '0;
        end else if (packet_enable) begin
            packet_type <= grant_type;
            if (grant == GRANT_AUDIO) begin
                audio_sample_word_packet  <= packed_words;
                audio_sample_word_present <= packed_present;
                frame_counter             <= next_frame;
                next_frame                <= frame_adv;
            end
        end
    end

    // A new request in the same cycle as an ACR grant keeps ACR pending.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acr_pending <= 1'b0;
            acr_skip    <= 1'b0;
        end else begin
            acr_pending <= acr_request || (acr_pending && (grant != GRANT_ACR));
            if (grant == GRANT_ACR) begin
                acr_skip <= 1'b0;
            end else if (grant == GRANT_AUDIO && acr_pending) begin
                acr_skip <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            field_count       <= '0;
            infoframe_pending <= '1;
        end else begin
            if (video_field_end) begin
                field_count <= field_wrap ? 4'd0 : field_count + 4'd1;
            end
            infoframe_pending <= (infoframe_pending & ~info_clear) | infoframe_update
                                 | {NUM_INFOFRAMES{field_wrap}};
        end
    end

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: a queue-based reference model predicts
// each packet slot and a monitor compares once the registered outputs settle.
module tb_packet_scheduler;
    import hdmi_packet_pkg::*;

    localparam int W     = 16;
    localparam int MAXS  = 2;
    localparam int DEPTH = 8;
    localparam int NIF   = 3;
    localparam int REP   = 2;
    localparam logic [23:0] IF_TYPES = {8'h83, 8'h82, 8'h84};

    logic                  clk_pixel = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  packet_enable = 1'b0;
    logic                  video_field_end = 1'b0;
    logic                  audio_sample_valid = 1'b0;
    logic                  audio_sample_ready;
    logic [1:0][W-1:0]     audio_sample_word = '0;
    logic                  acr_request = 1'b0;
    logic [NIF-1:0]        infoframe_update = '0;
    logic [7:0]            packet_type;
    logic [3:0][1:0][23:0] audio_sample_word_packet;
    logic [3:0]            audio_sample_word_present;
    logic [7:0]            frame_counter;
    logic [NIF-1:0]        infoframe_pending;

    always #5 clk_pixel = ~clk_pixel;

    packet_scheduler #(
        .AUDIO_BIT_WIDTH        (W),
        .MAX_SAMPLES_PER_PACKET (MAXS),
        .AUDIO_FIFO_DEPTH       (DEPTH),
        .NUM_INFOFRAMES         (NIF),
        .INFOFRAME_TYPES        (IF_TYPES),
        .REPEAT_FIELDS          (REP)
    ) dut (
        .clk_pixel                 (clk_pixel),
        .reset_n                   (reset_n),
        .packet_enable             (packet_enable),
        .video_field_end           (video_field_end),
        .audio_sample_valid        (audio_sample_valid),
        .audio_sample_ready        (audio_sample_ready),
        .audio_sample_word         (audio_sample_word),
        .acr_request               (acr_request),
        .infoframe_update          (infoframe_update),
        .packet_type               (packet_type),
        .audio_sample_word_packet  (audio_sample_word_packet),
        .audio_sample_word_present (audio_sample_word_present),
        .frame_counter             (frame_counter),
        .infoframe_pending         (infoframe_pending)
    );

    typedef struct {
        logic [7:0]            ptype;
        logic [3:0][1:0][23:0] words;
        logic [3:0]            present;
        logic [7:0]            frame;
        logic [NIF-1:0]        pending;
    } exp_t;

    exp_t             exp_q[$];
    logic [2*W-1:0]   model_fifo[$];
    bit               m_acr = 0;
    bit               m_skip = 0;
    logic [NIF-1:0]   m_pending = '1;
    int               m_field = 0;
    int               m_next_frame = 0;
    logic [3:0][1:0][23:0] m_words = '0;
    logic [3:0]       m_present = '0;
    logic [7:0]       m_frame = '0;
    int               total = 0;
    int               bad = 0;

    task automatic check_val(input string name, input logic [191:0] act, input logic [191:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Reference model: one call per clock cycle, using the state before that edge.
    task automatic model_step(input bit pe, input bit vfe, input bit valid,
                              input logic [2*W-1:0] sample, input bit acr,
                              input logic [NIF-1:0] upd);
        exp_t           e;
        int             n;
        bit             acr_grant = 0;
        bit             found = 0;
        bit             accept;
        logic [NIF-1:0] clr = '0;
        logic [2*W-1:0] s;
        accept = valid && (model_fifo.size() < DEPTH);
        e.ptype = PKT_NULL;
        if (pe) begin
            if (m_acr && m_skip) begin
                e.ptype = PKT_ACR;
                acr_grant = 1;
            end else if (model_fifo.size() > 0) begin
                n = (model_fifo.size() < MAXS) ? model_fifo.size() : MAXS;
                m_words = '0;
                for (int k = 0; k < n; k++) begin
                    s = model_fifo.pop_front();
                    for (int c = 0; c < 2; c++) m_words[k][c] = {s[c*W +: W], 8'h00};
                end
                m_present = 4'((1 << n) - 1);
                m_frame = 8'(m_next_frame);
                m_next_frame = (m_next_frame + n) % 192;
                if (m_acr) m_skip = 1;
                e.ptype = PKT_AUDIO_SAMPLE;
            end else if (m_acr) begin
                e.ptype = PKT_ACR;
                acr_grant = 1;
            end else begin
                for (int i = 0; i < NIF; i++) begin
                    if (!found && m_pending[i]) begin
                        found = 1;
                        e.ptype = IF_TYPES[i*8 +: 8];
                        clr[i] = 1'b1;
                    end
                end
            end
            if (acr_grant) m_skip = 0;
        end
        if (accept) model_fifo.push_back(sample);
        m_acr = acr ? 1 : (acr_grant ? 0 : m_acr);
        m_pending = m_pending & ~clr;
        if (vfe) begin
            if (m_field == REP - 1) begin
                m_field = 0;
                m_pending = '1;
            end else begin
                m_field++;
            end
        end
        m_pending = m_pending | upd;
        if (pe) begin
            e.words = m_words;
            e.present = m_present;
            e.frame = m_frame;
            e.pending = m_pending;
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit pe, input bit vfe, input bit valid,
                                 input logic [2*W-1:0] sample, input bit acr,
                                 input logic [NIF-1:0] upd);
        packet_enable      = pe;
        video_field_end    = vfe;
        audio_sample_valid = valid;
        audio_sample_word  = sample;
        acr_request        = acr;
        infoframe_update   = upd;
        check_val("ready", 192'(audio_sample_ready), 192'(model_fifo.size() < DEPTH));
        model_step(pe, vfe, valid, sample, acr, upd);
        @(posedge clk_pixel);
        #1;
        packet_enable      = 1'b0;
        video_field_end    = 1'b0;
        audio_sample_valid = 1'b0;
        acr_request        = 1'b0;
        infoframe_update   = '0;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_packet got=%0h want=none", packet_type);
        end else begin
            e = exp_q.pop_front();
            check_val("packet_type", 192'(packet_type), 192'(e.ptype));
            check_val("sample_words", audio_sample_word_packet, e.words);
            check_val("present", 192'(audio_sample_word_present), 192'(e.present));
            check_val("frame_counter", 192'(frame_counter), 192'(e.frame));
            check_val("infoframe_pending", 192'(infoframe_pending), 192'(e.pending));
        end
    endtask

    // Monitor: a packet_enable sampled on an edge means fresh outputs by the next negedge.
    always @(posedge clk_pixel) begin
        if (reset_n && packet_enable) begin
            @(negedge clk_pixel);
            checkOutput();
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        check_val("rst_packet_type", 192'(packet_type), 192'(8'h00));
        check_val("rst_words", audio_sample_word_packet, 192'(0));
        check_val("rst_present", 192'(audio_sample_word_present), 192'(0));
        check_val("rst_frame", 192'(frame_counter), 192'(0));
        check_val("rst_pending", 192'(infoframe_pending), 192'(3'b111));
        check_val("rst_ready", 192'(audio_sample_ready), 192'(1));
        #10;
        reset_n = 1'b1;
        @(posedge clk_pixel);
        #1;

        // InfoFrames after reset, lowest slot first, then null
        repeat (4) applyStimulus(1, 0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, '0, 0, '0);

        // Three samples packed two per packet
        applyStimulus(0, 0, 1, 32'h1234_ABCD, 0, '0);
        applyStimulus(0, 0, 1, 32'h5555_AAAA, 0, '0);
        applyStimulus(0, 0, 1, 32'hFFFF_0001, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0);

        // Backpressure: ten offered, eight taken, then a pop frees space
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, $urandom(), 0, '0);
        applyStimulus(1, 0, 1, $urandom(), 0, '0);
        applyStimulus(0, 0, 0, '0, 0, '0);
        repeat (5) applyStimulus(1, 0, 0, '0, 0, '0);

        // ACR under continuous audio: audio, ACR, audio
        for (int i = 0; i < 12; i++) applyStimulus(i % 2 == 1, 0, 1, $urandom(), i == 2, '0);
        repeat (8) applyStimulus(1, 0, 0, '0, 0, '0);

        // Field repeat and update-versus-grant collision
        applyStimulus(0, 1, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0);
        applyStimulus(0, 1, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, 3'b010);
        applyStimulus(1, 0, 0, '0, 0, '0);
        applyStimulus(0, 1, 0, '0, 0, '0);
        applyStimulus(1, 1, 0, '0, 0, '0);
        repeat (4) applyStimulus(1, 0, 0, '0, 0, '0);

        // Long stream to wrap the IEC frame index
        for (int i = 0; i < 1000; i++) applyStimulus(i % 2 == 1, 0, 1, $urandom(), 0, '0);
        repeat (3) applyStimulus(1, 0, 0, '0, 0, '0);

        // Random traffic on every input
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3,
                          $urandom_range(0, 9) < 6, $urandom(),
                          $urandom_range(0, 99) < 5,
                          ($urandom_range(0, 99) < 4) ? NIF'($urandom()) : '0);
        end

        repeat (3) applyStimulus(0, 0, 0, '0, 0, '0);
        check_val("scoreboard_drained", 192'(exp_q.size()), 192'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
